// File: rtl/rs_dec_out_ctrl.sv
// Output-side controller for the Reed-Solomon decoder core.
// Forwards the K information bytes of each corrected block as a framed byte
// stream, strips the parity symbols and attaches fail status and statistics.
module rs_dec_out_ctrl #(
    parameter int unsigned K = 223,
    parameter int unsigned N = 255
) (
    input  logic        ClkI_Dec8,
    input  logic        Rst,
    input  logic [7:0]  CodeOut,
    input  logic        OutValid,
    input  logic        OutStart,
    input  logic        DecFailI,
    output logic [7:0]  DataO,
    output logic        EnO,
    output logic        SofO,
    output logic        EofO,
    output logic        FailO,
    output logic        AbortO,
    output logic [15:0] BlkCnt,
    output logic [15:0] FailCnt,
    output logic        ProtoErr
);

    localparam int unsigned IDX_W  = 8;
    localparam int unsigned CNT_W  = 16;
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(K - 1);
    localparam logic [IDX_W-1:0] N_LAST = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             fail_q;

    // Block framing FSM with registered stream outputs and saturating statistics
    always_ff @(posedge ClkI_Dec8 or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            idx      <= '0;
            fail_q   <= 1'b0;
            DataO    <= 8'h00;
            EnO      <= 1'b0;
            SofO     <= 1'b0;
            EofO     <= 1'b0;
            FailO    <= 1'b0;
            AbortO   <= 1'b0;
            BlkCnt   <= '0;
            FailCnt  <= '0;
            ProtoErr <= 1'b0;
        end else begin
            // Stream strobes are single-cycle; DataO is zero on idle cycles
            DataO  <= 8'h00;
            EnO    <= 1'b0;
            SofO   <= 1'b0;
            EofO   <= 1'b0;
            FailO  <= 1'b0;
            AbortO <= 1'b0;

            if (OutValid) begin
                if (OutStart) begin
                    // A start outside IDLE abandons the running block without EofO
                    if (state != IDLE) begin
                        AbortO <= 1'b1;
                    end
                    DataO  <= CodeOut;
                    EnO    <= 1'b1;
                    SofO   <= 1'b1;
                    FailO  <= DecFailI;
                    fail_q <= DecFailI;
                    if (BlkCnt != CNT_MAX) begin
                        BlkCnt <= BlkCnt + CNT_W'(1);
                    end
                    if (DecFailI && (FailCnt != CNT_MAX)) begin
                        FailCnt <= FailCnt + CNT_W'(1);
                    end
                    idx <= IDX_W'(1);
                    // A one-byte information field ends on the start byte itself
                    if (K_LAST == '0) begin
                        EofO  <= 1'b1;
                        state <= PARITY;
                    end else begin
                        state <= DATA;
                    end
                end else begin
                    unique case (state)
                        IDLE: begin
                            ProtoErr <= 1'b1;
                        end
                        DATA: begin
                            DataO <= CodeOut;
                            EnO   <= 1'b1;
                            FailO <= fail_q;
                            idx   <= idx + IDX_W'(1);
                            if (idx == K_LAST) begin
                                EofO  <= 1'b1;
                                state <= PARITY;
                            end
                        end
                        PARITY: begin
                            if (idx == N_LAST) begin
                                idx   <= '0;
                                state <= IDLE;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                        default: begin
                            idx   <= '0;
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_dec_out_ctrl.sv
// Randomized self-checking bench for rs_dec_out_ctrl against a block-level
// reference model that tracks the position of each accepted symbol.
`timescale 1ns/1ps
module tb_rs_dec_out_ctrl;

    localparam int K = 223;
    localparam int N = 255;

    logic        clk;
    logic        Rst;
    logic [7:0]  CodeOut;
    logic        OutValid;
    logic        OutStart;
    logic        DecFailI;
    logic [7:0]  DataO;
    logic        EnO, SofO, EofO, FailO, AbortO, ProtoErr;
    logic [15:0] BlkCnt, FailCnt;

    int tests_run;
    int tests_failed;

    // Reference model state: position of last accepted symbol in block, -1 when idle
    int m_pos;
    bit m_fail;
    int m_blk;
    int m_fcnt;
    bit m_perr;

    rs_dec_out_ctrl #(.K(K), .N(N)) dut (
        .ClkI_Dec8 (clk),
        .Rst       (Rst),
        .CodeOut   (CodeOut),
        .OutValid  (OutValid),
        .OutStart  (OutStart),
        .DecFailI  (DecFailI),
        .DataO     (DataO),
        .EnO       (EnO),
        .SofO      (SofO),
        .EofO      (EofO),
        .FailO     (FailO),
        .AbortO    (AbortO),
        .BlkCnt    (BlkCnt),
        .FailCnt   (FailCnt),
        .ProtoErr  (ProtoErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector layout: [45:38] data, 37 en, 36 sof, 35 eof, 34 fail,
    // 33 abort, 32 protoerr, [31:16] blkcnt, [15:0] failcnt
    function automatic logic [45:0] observe();
        return {DataO, EnO, SofO, EofO, FailO, AbortO, ProtoErr, BlkCnt, FailCnt};
    endfunction

    task automatic model_reset();
        m_pos  = -1;
        m_fail = 1'b0;
        m_blk  = 0;
        m_fcnt = 0;
        m_perr = 1'b0;
    endtask

    // Expected outputs for one cycle given the symbol presented at the edge
    task automatic model_step(input bit v, input bit s, input bit d,
                              input logic [7:0] c, output logic [45:0] e);
        logic [7:0] dat;
        bit en, sof, eof, fl, ab;
        dat = 8'h00; en = 0; sof = 0; eof = 0; fl = 0; ab = 0;
        if (v) begin
            if (s) begin
                ab     = (m_pos >= 0);
                m_pos  = 0;
                m_fail = d;
                if (m_blk < 65535) m_blk++;
                if (d && m_fcnt < 65535) m_fcnt++;
                en = 1; sof = 1; dat = c; fl = d; eof = (K == 1);
            end else if (m_pos < 0) begin
                m_perr = 1'b1;
            end else begin
                m_pos++;
                if (m_pos < K) begin
                    en = 1; dat = c; fl = m_fail; eof = (m_pos == K - 1);
                end
                if (m_pos == N - 1) m_pos = -1;
            end
        end
        e = {dat, en, sof, eof, fl, ab, m_perr, 16'(m_blk), 16'(m_fcnt)};
    endtask

    // Present one input cycle, then capture DUT outputs and model expectation
    task automatic step(input bit v, input bit s, input bit d, input logic [7:0] c,
                        output logic [45:0] o, output logic [45:0] e);
        @(negedge clk);
        OutValid = v;
        OutStart = s;
        DecFailI = d;
        CodeOut  = c;
        @(posedge clk);
        #1;
        o = observe();
        model_step(v, s, d, c, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        Rst = 1'b0;
        OutValid = 1'b0; OutStart = 1'b0; DecFailI = 1'b0; CodeOut = 8'h00;
        repeat (2) @(negedge clk);
        Rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [45:0] o;
        Rst = 1'b0;
        OutValid = 1'b0; OutStart = 1'b0; DecFailI = 1'b0; CodeOut = 8'h00;
        repeat (3) @(negedge clk);
        o = observe();
        tests_run++;
        if (o !== 46'd0) begin
            tests_failed++;
            $display("FAIL reset_state got %h exp %h", o, 46'd0);
        end
        Rst = 1'b1;
        model_reset();
    endtask

    task automatic test_continuous();
        logic [45:0] o, e;
        int en_cnt;
        en_cnt = 0;
        do_reset();
        for (int i = 0; i < N; i++) begin
            step(1'b1, i == 0, 1'b0, 8'(i), o, e);
            if (o[37]) en_cnt++;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL continuous idx %0d got %h exp %h", i, o, e);
            end
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, o, e);
        tests_run++;
        if (en_cnt != K || BlkCnt !== 16'd1 || FailCnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL continuous_totals got en=%0d blk=%0d fail=%0d exp en=%0d blk=1 fail=0",
                     en_cnt, BlkCnt, FailCnt, K);
        end
    endtask

    task automatic test_gaps();
        logic [45:0] o, e;
        int i, cyc, en_cnt;
        bit v;
        i = 0; cyc = 0; en_cnt = 0;
        do_reset();
        while (i < N && cyc < 4000) begin
            v = ($urandom_range(0, 1) == 1);
            if (v) begin
                step(1'b1, i == 0, 1'b0, 8'(i), o, e);
                i++;
            end else begin
                step(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), o, e);
            end
            cyc++;
            if (o[37]) en_cnt++;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL gaps cyc %0d got %h exp %h", cyc, o, e);
            end
        end
        tests_run++;
        if (i != N || en_cnt != K) begin
            tests_failed++;
            $display("FAIL gaps_totals got sent=%0d en=%0d exp sent=%0d en=%0d", i, en_cnt, N, K);
        end
    endtask

    task automatic test_back_to_back();
        logic [45:0] o, e;
        int ab_cnt, fail_bytes;
        ab_cnt = 0; fail_bytes = 0;
        do_reset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N; i++) begin
                step(1'b1, i == 0, b == 1, 8'($urandom), o, e);
                if (o[33]) ab_cnt++;
                if (b == 1 && o[37] && o[34]) fail_bytes++;
                tests_run++;
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL back_to_back blk %0d idx %0d got %h exp %h", b, i, o, e);
                end
            end
        end
        tests_run++;
        if (ab_cnt != 0 || fail_bytes != K || BlkCnt !== 16'd2 || FailCnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL back_to_back_totals got abort=%0d failbytes=%0d blk=%0d fail=%0d exp 0 %0d 2 1",
                     ab_cnt, fail_bytes, BlkCnt, FailCnt, K);
        end
    endtask

    task automatic test_premature();
        logic [45:0] o, e;
        int ab_cnt, eof_cnt;
        ab_cnt = 0; eof_cnt = 0;
        do_reset();
        for (int i = 0; i < 101 + N; i++) begin
            step(1'b1, (i == 0) || (i == 100), 1'b0, 8'($urandom), o, e);
            if (o[33]) ab_cnt++;
            if (o[35]) eof_cnt++;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL premature idx %0d got %h exp %h", i, o, e);
            end
        end
        tests_run++;
        if (ab_cnt != 1 || eof_cnt != 1 || BlkCnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL premature_totals got abort=%0d eof=%0d blk=%0d exp 1 1 2",
                     ab_cnt, eof_cnt, BlkCnt);
        end
    endtask

    task automatic test_proto_err();
        logic [45:0] o, e;
        int en_cnt;
        en_cnt = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'($urandom), o, e);
            if (o[37]) en_cnt++;
        end
        tests_run++;
        if (en_cnt != 0 || ProtoErr !== 1'b1) begin
            tests_failed++;
            $display("FAIL proto_err_set got en=%0d perr=%b exp en=0 perr=1", en_cnt, ProtoErr);
        end
        for (int i = 0; i < N; i++) begin
            step(1'b1, i == 0, 1'b0, 8'(i), o, e);
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL proto_err_block idx %0d got %h exp %h", i, o, e);
            end
        end
        tests_run++;
        if (ProtoErr !== 1'b1) begin
            tests_failed++;
            $display("FAIL proto_err_sticky got %b exp 1", ProtoErr);
        end
    endtask

    task automatic test_reset_mid();
        logic [45:0] o, e;
        int en_cnt, eof_cnt;
        en_cnt = 0; eof_cnt = 0;
        do_reset();
        for (int i = 0; i < 50; i++) step(1'b1, i == 0, 1'b1, 8'($urandom), o, e);
        @(negedge clk);
        Rst = 1'b0;
        #1;
        o = observe();
        tests_run++;
        if (o !== 46'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_clear got %h exp %h", o, 46'd0);
        end
        OutValid = 1'b1; OutStart = 1'b1;
        repeat (2) @(negedge clk);
        o = observe();
        tests_run++;
        if (o !== 46'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_hold got %h exp %h", o, 46'd0);
        end
        OutValid = 1'b0; OutStart = 1'b0;
        Rst = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) begin
            step(1'b1, i == 0, 1'b0, 8'(i), o, e);
            if (o[37]) en_cnt++;
            if (o[35]) eof_cnt++;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL reset_mid_block idx %0d got %h exp %h", i, o, e);
            end
        end
        tests_run++;
        if (en_cnt != K || eof_cnt != 1 || BlkCnt !== 16'd1 || FailCnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_totals got en=%0d eof=%0d blk=%0d fail=%0d exp %0d 1 1 0",
                     en_cnt, eof_cnt, BlkCnt, FailCnt, K);
        end
    endtask

    task automatic test_random_mix();
        logic [45:0] o, e;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, 1'($urandom),
                 8'($urandom), o, e);
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL random_mix cyc %0d got %h exp %h", i, o, e);
            end
        end
    endtask

    task automatic test_saturation();
        logic [45:0] o, e;
        do_reset();
        for (int i = 0; i < 65540; i++) step(1'b1, 1'b1, 1'b1, 8'($urandom), o, e);
        tests_run++;
        if (o !== e || BlkCnt !== 16'hFFFF || FailCnt !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL saturation got %h exp %h", o, e);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        OutValid = 1'b0; OutStart = 1'b0; DecFailI = 1'b0; CodeOut = 8'h00;
        Rst = 1'b0;
        model_reset();
        test_reset();
        test_continuous();
        test_gaps();
        test_back_to_back();
        test_premature();
        test_proto_err();
        test_reset_mid();
        test_random_mix();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
